mp_addsub_seq: RTL and testbench
================================

Name: mp_addsub_seq

Overview:
- Byte-serial multi-precision add/subtract controller built around the team's 8-bit add/sub datapath: one byte slice per clock, least-significant byte first, carry chained between bytes.
- Lets the ALU perform wide (default 32-bit) add and subtract with one 8-bit adder.
- start/busy/done handshake toward the issuing control unit.
- Subtract semantics match the 8-bit slice: R = X + ~Y + 1; carry-out G=1 means no borrow.

Parameters:
NBYTES, 4, operand width in bytes (>=2); data width W = 8*NBYTES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  operation request, sampled only in IDLE
X  input  W  operand A, captured at accept
Y  input  W  operand B, captured at accept
M  input  1  mode at accept: 0 = X+Y, 1 = X-Y
R  output  W  result, registered
G  output  1  final carry-out of the top byte (sub: 1 = no borrow)
Z  output  1  1 when R == 0, valid with done
busy  output  1  high while not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous, any state: state=IDLE, byte index=0, R=0, G=0, Z=0, busy=0, done=0, internal carry=0. Reset mid-operation aborts; no partial result survives.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a rising edge (accept edge E0):
  - latch X, Y, M
  - byte index=0, internal carry=M, R=0, G=0, Z=0
  - go to RUN
- IDLE, start=0: hold state; R/G/Z keep the last result.
- RUN, each edge Ek, k=1..NBYTES, i=k-1:
  - b = M ? ~Y[8i+7:8i] : Y[8i+7:8i]
  - {c, s} = X[8i+7:8i] + b + carry, computed as a 9-bit sum
  - write R[8i+7:8i]=s, carry=c
  - at i=NBYTES-1: G=c, Z=(full R incl. new byte == 0), go to DONE
  - else index+1
- DONE, one cycle: done=1, busy=1. At the next edge go to IDLE with done=0.
- Timing: done is high in the cycle after edge E_NBYTES. Latency accept-to-done = NBYTES+1 edges. Minimum start-to-start spacing = NBYTES+2 cycles.
- busy=1 from the edge after accept through the DONE cycle. busy and done are registered and glitch-free.
- start while RUN or DONE is ignored, not queued. X/Y/M changes after accept have no effect.
- R bytes update progressively during RUN. R is valid only when done=1, and holds until the next accept.
- No overflow flag. Signed overflow is derived externally if needed.
- Wrap-around is modulo 2^W:
  - add with carry out of the top byte → G=1
  - sub with X<Y (unsigned) → G=0 and R = two's-complement wrap

Test Plan (NBYTES=4):
- Carry across a byte boundary: X=0x000000FF, Y=0x00000001, M=0, pulse start → done 5 edges after accept; R=0x00000100, G=0, Z=0; busy high 5 cycles.
- Full wrap: X=0xFFFFFFFF, Y=0x00000001, M=0 → R=0x00000000, G=1, Z=1.
- Subtract with borrow: X=0x00000001, Y=0x00000002, M=1 → R=0xFFFFFFFF, G=0, Z=0.
- Equal-operand subtract: X=0x12345678, Y=0x12345678, M=1 → R=0, G=1, Z=1. Then X=0x00010000, Y=0x00000001, M=1 → R=0x0000FFFF, G=1.
- Busy protection: accept X=4, Y=1, M=0; two edges later assert start with X=1, Y=2, M=1 → ignored. R=0x00000005 at done, exactly one done pulse, and no second operation starts until start is reasserted in IDLE.
- Reset mid-op: accept an operation, assert reset asynchronously after edge E2 → R=0, G=0, Z=0, busy=0, done=0 immediately. After release, a new start runs a full NBYTES+1 latency with a correct result.

Source files
------------

// File: rtl/mp_addsub_seq_if.sv
// Handshake and operand/result bundle for the byte-serial multi-precision add/sub controller.
interface mp_addsub_seq_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         M;
  logic [W-1:0] R;
  logic         G;
  logic         Z;
  logic         busy;
  logic         done;

  modport master (
    output start, X, Y, M,
    input  R, G, Z, busy, done
  );

  modport slave (
    input  start, X, Y, M,
    output R, G, Z, busy, done
  );
endinterface

// File: rtl/mp_addsub_seq.sv
// Byte-serial wide add/subtract: one 8-bit slice per clock, LSB first, carry chained between
// bytes. Subtract is X + ~Y + 1, so G=1 on subtract means no borrow.
module mp_addsub_seq #(
  parameter int unsigned NBYTES = 4
) (
  input logic            clk,
  input logic            reset,
  mp_addsub_seq_if.slave bus
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic          m_q, m_d;
  logic [W-1:0]  r_q, r_d;
  logic          g_q, g_d;
  logic          z_q, z_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    xb;
  logic [7:0]    yb;
  logic [8:0]    sum;

  // Current byte slice; Y is inverted for subtract and the +1 enters as the initial carry.
  always_comb begin
    xb  = x_q[{idx_q, 3'b000} +: 8];
    yb  = y_q[{idx_q, 3'b000} +: 8] ^ {8{m_q}};
    sum = {1'b0, xb} + {1'b0, yb} + {8'd0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    r_d     = r_q;
    g_d     = g_q;
    z_d     = z_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          m_d     = bus.M;
          idx_d   = '0;
          carry_d = bus.M;
          r_d     = '0;
          g_d     = 1'b0;
          z_d     = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        r_d[{idx_q, 3'b000} +: 8] = sum[7:0];
        carry_d = sum[8];
        if (idx_q == LastIdx) begin
          g_d     = sum[8];
          z_d     = (r_d == '0);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flag outputs are registered copies of the next state so they never glitch.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= 1'b0;
      r_q     <= '0;
      g_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m_q     <= m_d;
      r_q     <= r_d;
      g_q     <= g_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.R    = r_q;
  assign bus.G    = g_q;
  assign bus.Z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq (NBYTES=4) with a result scoreboard and immediate assertions.
module tb_mp_addsub_seq;
  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         g;
    logic         z;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  mp_addsub_seq_if #(.NBYTES(NBYTES)) bus ();

  mp_addsub_seq #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: full-width arithmetic with one extra bit for the carry.
  task automatic push_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    logic [W:0] full;
    exp_t       e;
    if (m) full = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    else   full = {1'b0, x} + {1'b0, y};
    e.r = full[W-1:0];
    e.g = full[W];
    e.z = (full[W-1:0] == '0);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_R"}, bus.R, e.r);
      chk({tag, "_G"}, {31'd0, bus.G}, {31'd0, e.g});
      chk({tag, "_Z"}, {31'd0, bus.Z}, {31'd0, e.z});
    end
  endtask

  // Drive one operation, measure latency and busy cycles, then score the result.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic m);
    int edges;
    int busy_cnt;
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    bus.M = m;
    bus.start = 1'b1;
    push_model(x, y, m);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 1;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_latency"}, edges, NBYTES + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, NBYTES + 1);
    pop_check(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    bus.M = 1'b0;
    #12;
    chk("rst_R", bus.R, 32'd0);
    chk("rst_G", {31'd0, bus.G}, 32'd0);
    chk("rst_Z", {31'd0, bus.Z}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("carry_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op("full_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_borrow", 32'h0000_0001, 32'h0000_0002, 1'b1);
    run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1);
    run_op("sub_chain", 32'h0001_0000, 32'h0000_0001, 1'b1);
    run_op("add_mixed", 32'h89AB_CDEF, 32'h7654_3211, 1'b0);

    // Start while busy must be ignored and must not queue a second operation.
    @(negedge clk);
    bus.X = 32'd4;
    bus.Y = 32'd1;
    bus.M = 1'b0;
    bus.start = 1'b1;
    push_model(32'd4, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.X = 32'd1;
    bus.Y = 32'd2;
    bus.M = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_prot_done", {31'd0, bus.done}, 32'd1);
    pop_check("busy_prot");
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
    chk("busy_prot_extra_done", done_cnt, 0);
    chk("busy_prot_extra_busy", busy_cnt, 0);
    chk("busy_prot_R_hold", bus.R, 32'd5);

    // Asynchronous reset mid-operation discards the partial result.
    @(negedge clk);
    bus.X = 32'h0101_0101;
    bus.Y = 32'h0000_0000;
    bus.M = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midop_partial_R", bus.R, 32'h0000_0101);
    chk("midop_busy", {31'd0, bus.busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("midop_rst_R", bus.R, 32'd0);
    chk("midop_rst_G", {31'd0, bus.G}, 32'd0);
    chk("midop_rst_Z", {31'd0, bus.Z}, 32'd0);
    chk("midop_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midop_rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_rst", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
